spiifc: RTL and testbench

SPI slave front end that bridges an external SPI master to on-chip byte memories and a small register file. All logic runs on the system clock, which oversamples the SPI pins. Received data bytes are written into a receive memory through a write port. Transmit bytes are fetched from a transmit memory through a synchronous read port.

---
 rtl/spiifc_pkg.sv | 23 ++
 rtl/spiifc_sync.sv | 38 +++
 rtl/spiifc.sv | 198 +++++++++++++++++++
 tb/tb_spiifc.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spiifc_pkg.sv
// rtl/spiifc_pkg.sv - opcodes, sizes and FSM state type shared by the SPI slave front end
package spiifc_pkg;

  localparam int ADDR_W   = 12;
  localparam int NUM_REGS = 8;

  localparam logic [7:0] OP_WRITE_MEM = 8'h01;
  localparam logic [7:0] OP_READ_MEM  = 8'h02;
  localparam logic [7:0] OP_WRITE_REG = 8'h03;
  localparam logic [7:0] OP_READ_REG  = 8'h04;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WMEM,
    ST_RMEM,
    ST_REGIDX,
    ST_REGDATA,
    ST_REGRD,
    ST_IGNORE
  } spiStateT;

endpackage

// File: rtl/spiifc_sync.sv
// rtl/spiifc_sync.sv - SPI pin synchronizers and SPI_CLK edge detection in the SysClk domain
module spiifc_sync (
  input  logic clk,
  input  logic rstN,
  input  logic spiClk,
  input  logic spiSs,
  input  logic spiMosi,
  output logic sclkRise,
  output logic sclkFall,
  output logic ssSync,
  output logic mosiSync
);

  // clkPipe[2] is the previous synchronized sample, used only for edge detection
  logic [2:0] clkPipe;
  logic [1:0] ssPipe;
  logic [1:0] mosiPipe;

  // Two-flop synchronizers. The SS chain resets low so that a select held low
  // across reset never looks like an idle line that just went active.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      clkPipe  <= 3'b000;
      ssPipe   <= 2'b00;
      mosiPipe <= 2'b00;
    end else begin
      clkPipe  <= {clkPipe[1:0], spiClk};
      ssPipe   <= {ssPipe[0], spiSs};
      mosiPipe <= {mosiPipe[0], spiMosi};
    end
  end

  assign sclkRise = clkPipe[1] & ~clkPipe[2];
  assign sclkFall = ~clkPipe[1] & clkPipe[2];
  assign ssSync   = ssPipe[1];
  assign mosiSync = mosiPipe[1];

endmodule

// File: rtl/spiifc.sv
// rtl/spiifc.sv - SPI mode-0 slave bridging to rx/tx byte memories and an 8-entry register file (option: SPIIFC_DEBUG_EN)
module spiifc
  import spiifc_pkg::*;
(
  input  logic              SysClk,
  input  logic              Reset,
  input  logic              SPI_CLK,
  input  logic              SPI_MOSI,
  input  logic              SPI_SS,
  output logic              SPI_MISO,
  output logic [ADDR_W-1:0] txMemAddr,
  input  logic [7:0]        txMemData,
  output logic [ADDR_W-1:0] rcMemAddr,
  output logic [7:0]        rcMemData,
  output logic              rcMemWE,
  output logic [7:0]        debug_out
);

  logic       sclkRise, sclkFall, ssSync, mosiSync;
  spiStateT   state, stateNext;
  logic       armed;
  logic [2:0] bitCnt;
  logic [7:0] shiftIn, shiftOut;
  logic       byteDone;
  logic [7:0] rxByte;
  logic       regWriteOp;
  logic [2:0] regIdx;
  logic [7:0] regFile [NUM_REGS];

  logic       memWrite, regWrite, idxLoad, opLatch, wAddrClear, txStart, txNext;
  logic [7:0] loadVal;

  spiifc_sync uSync (
    .clk      (SysClk),
    .rstN     (Reset),
    .spiClk   (SPI_CLK),
    .spiSs    (SPI_SS),
    .spiMosi  (SPI_MOSI),
    .sclkRise (sclkRise),
    .sclkFall (sclkFall),
    .ssSync   (ssSync),
    .mosiSync (mosiSync)
  );

  // A byte completes on the 8th synchronized rising edge; rxByte includes that last bit.
  assign byteDone = sclkRise && !ssSync && (state != ST_IDLE) && (bitCnt == 3'd7);
  assign rxByte   = {shiftIn[6:0], mosiSync};
  assign SPI_MISO = shiftOut[7];

  // State register
  always_ff @(posedge SysClk or negedge Reset) begin
    if (!Reset) state <= ST_IDLE;
    else        state <= stateNext;
  end

  // Next-state: SS high always returns to IDLE; the command byte selects the branch
  always_comb begin
    stateNext = state;
    if (ssSync) begin
      stateNext = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (armed) stateNext = ST_CMD;
        ST_CMD: begin
          if (byteDone) begin
            case (rxByte)
              OP_WRITE_MEM:              stateNext = ST_WMEM;
              OP_READ_MEM:               stateNext = ST_RMEM;
              OP_WRITE_REG, OP_READ_REG: stateNext = ST_REGIDX;
              default:                   stateNext = ST_IGNORE;
            endcase
          end
        end
        ST_REGIDX:  if (byteDone) stateNext = regWriteOp ? ST_REGDATA : ST_REGRD;
        ST_REGDATA: if (byteDone) stateNext = ST_IGNORE;
        ST_REGRD:   if (byteDone) stateNext = ST_IGNORE;
        default:    stateNext = state;
      endcase
    end
  end

  // Output decode: per-byte strobes and the next MISO byte (0x00 unless something is returned)
  always_comb begin
    memWrite   = 1'b0;
    regWrite   = 1'b0;
    idxLoad    = 1'b0;
    opLatch    = 1'b0;
    wAddrClear = 1'b0;
    txStart    = 1'b0;
    txNext     = 1'b0;
    loadVal    = 8'h00;
    case (state)
      ST_CMD: begin
        if (byteDone) begin
          opLatch    = 1'b1;
          wAddrClear = (rxByte == OP_WRITE_MEM);
          if (rxByte == OP_READ_MEM) begin
            txStart = 1'b1;
            loadVal = txMemData;
          end
        end
      end
      ST_WMEM:    memWrite = byteDone;
      ST_RMEM: begin
        if (byteDone) begin
          txNext  = 1'b1;
          loadVal = txMemData;
        end
      end
      ST_REGIDX: begin
        if (byteDone) begin
          idxLoad = 1'b1;
          if (!regWriteOp) loadVal = regFile[rxByte[2:0]];
        end
      end
      ST_REGDATA: regWrite = byteDone;
      default: ;
    endcase
  end

  // A transaction may only start once SS has been seen high after reset
  always_ff @(posedge SysClk or negedge Reset) begin
    if (!Reset)      armed <= 1'b0;
    else if (ssSync) armed <= 1'b1;
  end

  // Bit counter and MOSI shifter; leaving the frame discards any partial byte
  always_ff @(posedge SysClk or negedge Reset) begin
    if (!Reset) begin
      bitCnt  <= 3'd0;
      shiftIn <= 8'h00;
    end else if (ssSync || state == ST_IDLE) begin
      bitCnt  <= 3'd0;
    end else if (sclkRise) begin
      bitCnt  <= bitCnt + 3'd1;
      shiftIn <= rxByte;
    end
  end

  // MISO shifter: reload at byte end; the falling edge right after the 8th rise
  // is skipped so the freshly loaded MSB stays on the pin for the next byte
  always_ff @(posedge SysClk or negedge Reset) begin
    if (!Reset)                                shiftOut <= 8'h00;
    else if (ssSync || state == ST_IDLE)       shiftOut <= 8'h00;
    else if (byteDone)                         shiftOut <= loadVal;
    else if (sclkFall && bitCnt != 3'd0)       shiftOut <= {shiftOut[6:0], 1'b0};
  end

  // Transmit address: parked at 0 during the command byte so txMem[0] is ready at decode,
  // then prefetches one byte ahead
  always_ff @(posedge SysClk or negedge Reset) begin
    if (!Reset)              txMemAddr <= '0;
    else if (state == ST_CMD) txMemAddr <= {{(ADDR_W-1){1'b0}}, txStart};
    else if (txNext)          txMemAddr <= txMemAddr + ADDR_W'(1);
  end

  // Receive memory port: one-cycle write pulse, address advances after the pulse
  always_ff @(posedge SysClk or negedge Reset) begin
    if (!Reset) begin
      rcMemWE   <= 1'b0;
      rcMemAddr <= '0;
      rcMemData <= 8'h00;
    end else begin
      rcMemWE <= memWrite;
      if (wAddrClear)   rcMemAddr <= '0;
      else if (rcMemWE) rcMemAddr <= rcMemAddr + ADDR_W'(1);
      if (memWrite)     rcMemData <= rxByte;
    end
  end

  // Register file, latched opcode kind and register index
  always_ff @(posedge SysClk or negedge Reset) begin
    if (!Reset) begin
      regWriteOp <= 1'b0;
      regIdx     <= 3'd0;
      for (int i = 0; i < NUM_REGS; i++) regFile[i] <= 8'h00;
    end else begin
      if (opLatch)  regWriteOp      <= (rxByte == OP_WRITE_REG);
      if (idxLoad)  regIdx          <= rxByte[2:0];
      if (regWrite) regFile[regIdx] <= rxByte;
    end
  end

`ifdef SPIIFC_DEBUG_EN
  logic [7:0] debugByte;

  // Debug capture of the most recent complete byte
  always_ff @(posedge SysClk or negedge Reset) begin
    if (!Reset)        debugByte <= 8'h00;
    else if (byteDone) debugByte <= rxByte;
  end

  assign debug_out = debugByte;
`else
  assign debug_out = 8'h00;
`endif

endmodule

// File: tb/tb_spiifc.sv
// tb/tb_spiifc.sv - randomized self-checking bench for spiifc against a transaction-level model
module tb_spiifc;

  logic        SysClk = 1'b0;
  logic        Reset, SPI_CLK, SPI_MOSI, SPI_SS;
  logic        SPI_MISO;
  logic [11:0] txMemAddr, rcMemAddr;
  logic [7:0]  txMemData, rcMemData, debug_out;
  logic        rcMemWE;

  int passCnt  = 0;
  int checkCnt = 0;

  logic [7:0]  txMem    [4096];
  logic [7:0]  regModel [8];
  logic [19:0] wrLog    [$];
  logic [7:0]  txq      [$];
  logic [7:0]  rxq      [$];

  spiifc dut (
    .SysClk    (SysClk),
    .Reset     (Reset),
    .SPI_CLK   (SPI_CLK),
    .SPI_MOSI  (SPI_MOSI),
    .SPI_SS    (SPI_SS),
    .SPI_MISO  (SPI_MISO),
    .txMemAddr (txMemAddr),
    .txMemData (txMemData),
    .rcMemAddr (rcMemAddr),
    .rcMemData (rcMemData),
    .rcMemWE   (rcMemWE),
    .debug_out (debug_out)
  );

  always #5 SysClk = ~SysClk;

  always @(posedge SysClk) txMemData <= txMem[txMemAddr];

  always @(negedge SysClk) if (rcMemWE) wrLog.push_back({rcMemAddr, rcMemData});

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic spiXfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      SPI_MOSI = tx[i];
      #40;
      SPI_CLK = 1'b1;
      rx[i] = SPI_MISO;
      #40;
      SPI_CLK = 1'b0;
    end
    #40;
  endtask

  task automatic runFrame();
    logic [7:0] r;
    rxq = {};
    SPI_SS = 1'b0;
    #80;
    foreach (txq[i]) begin
      spiXfer(txq[i], r);
      rxq.push_back(r);
    end
    SPI_SS = 1'b1;
    #120;
  endtask

  task automatic readReg(input logic [7:0] idx, output logic [7:0] val, output logic [7:0] after);
    txq = {8'h04, idx, 8'($urandom), 8'($urandom)};
    runFrame();
    val   = rxq[2];
    after = rxq[3];
  endtask

  task automatic test_reset();
    Reset = 1'b0; SPI_SS = 1'b1; SPI_CLK = 1'b0; SPI_MOSI = 1'b0;
    for (int i = 0; i < 8; i++) regModel[i] = 8'h00;
    #40;
    checkCnt++; if (SPI_MISO !== 1'b0) $display("FAIL reset_miso got %b want 0", SPI_MISO); else passCnt++;
    checkCnt++; if (txMemAddr !== 12'h000) $display("FAIL reset_txaddr got %h want 000", txMemAddr); else passCnt++;
    checkCnt++; if (rcMemAddr !== 12'h000) $display("FAIL reset_rcaddr got %h want 000", rcMemAddr); else passCnt++;
    checkCnt++; if (rcMemData !== 8'h00) $display("FAIL reset_rcdata got %h want 00", rcMemData); else passCnt++;
    checkCnt++; if (rcMemWE !== 1'b0) $display("FAIL reset_we got %b want 0", rcMemWE); else passCnt++;
    checkCnt++; if (debug_out !== 8'h00) $display("FAIL reset_debug got %h want 00", debug_out); else passCnt++;
    Reset = 1'b1;
    #100;
    checkCnt++; if (SPI_MISO !== 1'b0) $display("FAIL post_reset_miso got %b want 0", SPI_MISO); else passCnt++;
  endtask

  task automatic checkWrites(input string name, input logic [7:0] data [$]);
    checkCnt++;
    if (wrLog.size() != data.size()) $display("FAIL %s_count got %0d want %0d", name, wrLog.size(), data.size());
    else passCnt++;
    foreach (data[k]) begin
      checkCnt++;
      if (k >= wrLog.size() || wrLog[k] !== {12'(k), data[k]})
        $display("FAIL %s_write%0d got %h want %h", name, k, (k < wrLog.size()) ? wrLog[k] : 20'hxxxxx, {12'(k), data[k]});
      else passCnt++;
    end
  endtask

  task automatic test_write_mem();
    logic [7:0] data [$];
    int n;
    data = {8'hA5, 8'h3C};
    wrLog = {};
    txq = {8'h01, 8'hA5, 8'h3C};
    runFrame();
    checkWrites("wmem_dir", data);
    for (int t = 0; t < 3; t++) begin
      n = $urandom_range(1, 6);
      data = {};
      for (int k = 0; k < n; k++) data.push_back(8'($urandom));
      wrLog = {};
      txq = {8'h01};
      foreach (data[k]) txq.push_back(data[k]);
      runFrame();
      checkWrites("wmem_rnd", data);
    end
  endtask

  task automatic test_regs();
    logic [7:0] v, a, idx, val, expDbg;
    txq = {8'h03, 8'h02, 8'h7E};
    runFrame();
    regModel[2] = 8'h7E;
    txq = {8'h04, 8'h02, 8'h00, 8'h00};
    runFrame();
    checkCnt++; if (rxq[0] !== 8'h00 || rxq[1] !== 8'h00) $display("FAIL rreg_lead got %h %h want 00 00", rxq[0], rxq[1]); else passCnt++;
    checkCnt++; if (rxq[2] !== 8'h7E) $display("FAIL rreg_dir got %h want 7e", rxq[2]); else passCnt++;
    checkCnt++; if (rxq[3] !== 8'h00) $display("FAIL rreg_tail got %h want 00", rxq[3]); else passCnt++;
    checkCnt++; if (debug_out !== 8'h00) $display("FAIL debug_rreg got %h want 00", debug_out); else passCnt++;
    for (int t = 0; t < 6; t++) begin
      idx = 8'($urandom);
      val = 8'($urandom);
      txq = {8'h03, idx, val};
      if (t[0]) txq.push_back(8'($urandom));
      runFrame();
      if (!t[0]) begin
`ifdef SPIIFC_DEBUG_EN
        expDbg = val;
`else
        expDbg = 8'h00;
`endif
        checkCnt++; if (debug_out !== expDbg) $display("FAIL debug_wreg got %h want %h", debug_out, expDbg); else passCnt++;
      end
      regModel[idx[2:0]] = val;
    end
    for (int r = 0; r < 8; r++) begin
      readReg({5'($urandom), 3'(r)}, v, a);
      checkCnt++; if (v !== regModel[r]) $display("FAIL rreg%0d got %h want %h", r, v, regModel[r]); else passCnt++;
      checkCnt++; if (a !== 8'h00) $display("FAIL rreg%0d_tail got %h want 00", r, a); else passCnt++;
    end
  endtask

  task automatic test_read_mem();
    logic [7:0] r;
    int n;
    txMem[0] = 8'h81;
    txMem[1] = 8'h42;
    for (int t = 0; t < 2; t++) begin
      n = (t == 0) ? 2 : $urandom_range(3, 6);
      SPI_SS = 1'b0;
      #80;
      checkCnt++; if (txMemAddr !== 12'h000) $display("FAIL rmem_addr_start got %h want 000", txMemAddr); else passCnt++;
      spiXfer(8'h02, r);
      checkCnt++; if (r !== 8'h00) $display("FAIL rmem_cmd_miso got %h want 00", r); else passCnt++;
      checkCnt++; if (txMemAddr !== 12'h001) $display("FAIL rmem_addr_cmd got %h want 001", txMemAddr); else passCnt++;
      for (int k = 0; k < n; k++) begin
        spiXfer(8'($urandom), r);
        checkCnt++; if (r !== txMem[k]) $display("FAIL rmem_byte%0d got %h want %h", k, r, txMem[k]); else passCnt++;
        checkCnt++; if (txMemAddr !== 12'(k + 2)) $display("FAIL rmem_addr%0d got %h want %h", k, txMemAddr, 12'(k + 2)); else passCnt++;
      end
      SPI_SS = 1'b1;
      #120;
      checkCnt++; if (SPI_MISO !== 1'b0) $display("FAIL rmem_miso_idle got %b want 0", SPI_MISO); else passCnt++;
    end
  endtask

  task automatic test_abort();
    logic [7:0] data [$];
    logic [7:0] r;
    wrLog = {};
    SPI_SS = 1'b0;
    #80;
    spiXfer(8'h01, r);
    for (int i = 7; i >= 4; i--) begin
      SPI_MOSI = r[i] ^ 1'b1;
      #40; SPI_CLK = 1'b1; #40; SPI_CLK = 1'b0;
    end
    #40;
    SPI_SS = 1'b1;
    #200;
    checkCnt++; if (wrLog.size() != 0) $display("FAIL abort_nowrite got %0d want 0", wrLog.size()); else passCnt++;
    data = {8'h11};
    wrLog = {};
    txq = {8'h01, 8'h11};
    runFrame();
    checkWrites("abort_next", data);
  endtask

  task automatic test_ignore();
    logic [7:0] v, a;
    logic [7:0] op;
    for (int t = 0; t < 3; t++) begin
      wrLog = {};
      do op = 8'($urandom); while (op >= 8'h01 && op <= 8'h04);
      txq = (t == 0) ? '{8'h55, 8'hFF} : '{op, 8'h03, 8'($urandom), 8'h01};
      runFrame();
      checkCnt++; if (wrLog.size() != 0) $display("FAIL ignore_nowrite got %0d want 0", wrLog.size()); else passCnt++;
      foreach (rxq[k]) begin
        checkCnt++; if (rxq[k] !== 8'h00) $display("FAIL ignore_miso%0d got %h want 00", k, rxq[k]); else passCnt++;
      end
    end
    readReg(8'h02, v, a);
    checkCnt++; if (v !== regModel[2]) $display("FAIL ignore_reg got %h want %h", v, regModel[2]); else passCnt++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] data [$];
    logic [7:0] r, v, a;
    wrLog = {};
    SPI_SS = 1'b0;
    #80;
    spiXfer(8'h01, r);
    Reset = 1'b0;
    #20;
    Reset = 1'b1;
    for (int i = 0; i < 8; i++) regModel[i] = 8'h00;
    #40;
    spiXfer(8'h99, r);
    spiXfer(8'h66, r);
    SPI_SS = 1'b1;
    #120;
    checkCnt++; if (wrLog.size() != 0) $display("FAIL rstmid_nowrite got %0d want 0", wrLog.size()); else passCnt++;
    data = {8'h22};
    wrLog = {};
    txq = {8'h01, 8'h22};
    runFrame();
    checkWrites("rstmid_next", data);
    readReg(8'h02, v, a);
    checkCnt++; if (v !== regModel[2]) $display("FAIL rstmid_reg got %h want %h", v, regModel[2]); else passCnt++;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) txMem[i] = 8'($urandom);
    test_reset();
    test_write_mem();
    test_regs();
    test_read_mem();
    test_abort();
    test_ignore();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
